dvs_event_unpacker: RTL and testbench
=====================================

DVS_EVENT_UNPACKER -- requirements
Module: dvs_event_unpacker

Interface
REQ-001 SHALL have parameter SENSOR_RES, default 320; the exclusive upper bound for event_x and event_y.
REQ-002 SHALL have parameter SYNC_BYTE, default 8'hA5; the packet header byte.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 1200; the maximum idle cycles allowed between bytes inside a packet.
REQ-004 SHALL have port clk, input, 1 bit; the single clock; all logic is on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit; synchronous active-high reset.
REQ-006 SHALL have port byte_valid, input, 1 bit; the upstream byte stream is valid.
REQ-007 SHALL have port byte_data, input, 8 bits; the upstream byte.
REQ-008 SHALL have port byte_ready, output, 1 bit; the block accepts a byte.
REQ-009 SHALL have ports event_valid (output, 1 bit) and event_ready (input, 1 bit); the event handshake toward the gesture accelerator.
REQ-010 SHALL have ports event_x (output, 9 bits), event_y (output, 9 bits), event_polarity (output, 1 bit) and event_ts (output, 16 bits).
REQ-011 SHALL have ports pkt_count (output, 8 bits) and err_count (output, 8 bits); saturating counts of emitted events and dropped packets.

Function
REQ-012 SHALL accept a byte only in a cycle where byte_valid and byte_ready are both high.
REQ-013 SHALL use this packet layout, in order:
- SYNC_BYTE
- x[7:0]
- y[7:0]
- flags {pol, 5'b0, y[8], x[8]}
- ts[15:8]
- ts[7:0]
- [checksum]
REQ-014 SHALL implement states HUNT, COLLECT and EMIT.
REQ-015 In HUNT, SHALL discard bytes that are not SYNC_BYTE and, on accepting SYNC_BYTE, move to COLLECT with the byte index cleared.
REQ-016 In COLLECT, SHALL store each accepted byte at the current index; a SYNC_BYTE value received here SHALL be treated as data.
REQ-017 When the final byte of a packet is accepted, SHALL run validation in that same cycle.
REQ-018 A packet SHALL fail validation when x >= SENSOR_RES, when y >= SENSOR_RES, or when the checksum fails (checksum enabled only).
REQ-019 On validation pass, SHALL load the output registers, enter EMIT and raise event_valid on the next cycle (1-cycle latency from the last byte).
REQ-020 On validation fail, SHALL return to HUNT and increment err_count; no event is emitted.
REQ-021 Reserved flag bits [6:2] SHALL be ignored.
REQ-022 In EMIT, SHALL hold event_valid and all event fields stable until event_valid and event_ready are both high, then increment pkt_count and return to HUNT.
REQ-023 byte_ready SHALL be 1 in HUNT and COLLECT, and 0 in EMIT and while rst is high.
REQ-024 In COLLECT, the idle counter SHALL count cycles with no accepted byte and clear on each accepted byte.
REQ-025 When the idle counter reaches TIMEOUT_CYCLES, SHALL return to HUNT and increment err_count.
REQ-026 pkt_count and err_count SHALL saturate at 255 and never wrap.
REQ-027 When a validation fail and a timeout occur in the same cycle, err_count SHALL increment once.
REQ-028 Width rule: event_x = {flags[0], x byte}; event_y = {flags[1], y byte}; event_polarity = flags[7]; event_ts = {ts_hi, ts_lo}.

Reset
REQ-029 While rst is high on a clock edge, SHALL set state=HUNT, byte index=0, idle counter=0, event_valid=0, event_x=0, event_y=0, event_polarity=0, event_ts=0, pkt_count=0, err_count=0.
REQ-030 A reset asserted mid-packet or during EMIT SHALL abandon the packet or event with no counter change.

Configuration
REQ-031 SHALL support macro UNPACK_CHECKSUM_EN.
REQ-032 With UNPACK_CHECKSUM_EN defined, the packet SHALL be 7 bytes; the checksum byte SHALL equal the XOR of bytes 1-5; a mismatch SHALL count as a validation fail.
REQ-033 Without UNPACK_CHECKSUM_EN, the packet SHALL be 6 bytes with no checksum logic; only the range check applies.

Verification
REQ-034 Scenario, valid event (checksum enabled, event_ready=1):
- Stimulus: A5 40 20 81 12 34 + correct checksum.
- Response: event_x=0x140 (320)? no, out of range; use A5 3F 20 81 12 34 + checksum.
- Required: x=0x13F, y=0x020, pol=1, ts=0x1234, event_valid 1 cycle after the last byte, pkt_count=1.
REQ-035 Scenario, bad checksum: valid packet with checksum XOR 0x01 -> no event_valid, err_count=1, state HUNT.
REQ-036 Scenario, x out of range: A5 40 00 01 00 00 (x=320) -> dropped, err_count=1.
REQ-037 Scenario, backpressure: event_ready=0 for 10 cycles after event_valid -> fields stable, byte_ready=0, transfer on the cycle event_ready rises, pkt_count=1.
REQ-038 Scenario, garbage then timeout:
- Stimulus: bytes 00 FF before A5, then 2 packet bytes, then TIMEOUT_CYCLES idle.
- Required: garbage is discarded, err_count=1 after the timeout, and the next valid packet decodes correctly.
REQ-039 Scenario, saturation: 300 bad packets -> err_count=255 and stays at 255.

Source files
------------

// File: rtl/dvs_event_unpacker.sv
// DVS event unpacker: resynchronises a byte stream on SYNC_BYTE, collects one packet,
// range-checks it and presents one event. Optional checksum byte: define UNPACK_CHECKSUM_EN.
module dvs_event_unpacker #(
    parameter int          SENSOR_RES     = 320,
    parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
    parameter int          TIMEOUT_CYCLES = 1200
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic        byte_ready,
    output logic        event_valid,
    input  logic        event_ready,
    output logic [8:0]  event_x,
    output logic [8:0]  event_y,
    output logic        event_polarity,
    output logic [15:0] event_ts,
    output logic [7:0]  pkt_count,
    output logic [7:0]  err_count
);

    localparam int             IW        = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [IW-1:0]  IDLE_LAST = IW'(TIMEOUT_CYCLES - 1);
    localparam logic [9:0]     RES_LIM   = 10'(SENSOR_RES);
`ifdef UNPACK_CHECKSUM_EN
    localparam logic [2:0]     LAST_IDX  = 3'd5;
`else
    localparam logic [2:0]     LAST_IDX  = 3'd4;
`endif

    typedef enum logic [1:0] {
        HUNT    = 2'd0,
        COLLECT = 2'd1,
        EMIT    = 2'd2
    } state_t;

    function automatic logic [7:0] f_sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

`ifdef UNPACK_CHECKSUM_EN
    function automatic logic [7:0] f_xor_step(input logic [7:0] acc, input logic [7:0] b);
        return acc ^ b;
    endfunction
`endif

    state_t          r_state;
    state_t          w_state_nxt;
    logic [2:0]      r_idx;
    logic [IW-1:0]   r_idle;
    logic [7:0]      r_x_lo;
    logic [7:0]      r_y_lo;
    logic            r_x8;
    logic            r_y8;
    logic            r_pol;
    logic [7:0]      r_ts_hi;
`ifdef UNPACK_CHECKSUM_EN
    logic [7:0]      r_ts_lo;
    logic [7:0]      r_csum;
`endif
    logic            r_ev_valid;
    logic [8:0]      r_ev_x;
    logic [8:0]      r_ev_y;
    logic            r_ev_pol;
    logic [15:0]     r_ev_ts;
    logic [7:0]      r_pkt_cnt;
    logic [7:0]      r_err_cnt;

    logic            w_accept;
    logic            w_last;
    logic            w_pass;
    logic            w_timeout;
    logic            w_load;
    logic            w_err;
    logic            w_done;
    logic [8:0]      w_x;
    logic [8:0]      w_y;
    logic [7:0]      w_ts_lo;

    assign byte_ready     = ~rst & (r_state != EMIT);
    assign w_accept       = byte_valid & byte_ready;
    assign w_last         = (r_idx == LAST_IDX);
    assign w_x            = {r_x8, r_x_lo};
    assign w_y            = {r_y8, r_y_lo};
    assign w_timeout      = (r_state == COLLECT) & ~w_accept & (r_idle == IDLE_LAST);

    // In the short format the timestamp low byte is the final byte, so it arrives live.
`ifdef UNPACK_CHECKSUM_EN
    assign w_ts_lo = r_ts_lo;
    assign w_pass  = ({1'b0, w_x} < RES_LIM) & ({1'b0, w_y} < RES_LIM) & (byte_data == r_csum);
`else
    assign w_ts_lo = byte_data;
    assign w_pass  = ({1'b0, w_x} < RES_LIM) & ({1'b0, w_y} < RES_LIM);
`endif

    assign event_valid    = r_ev_valid;
    assign event_x        = r_ev_x;
    assign event_y        = r_ev_y;
    assign event_polarity = r_ev_pol;
    assign event_ts       = r_ev_ts;
    assign pkt_count      = r_pkt_cnt;
    assign err_count      = r_err_cnt;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= HUNT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode plus load/error/done strobes.
    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_err       = 1'b0;
        w_done      = 1'b0;
        case (r_state)
            HUNT: begin
                if (w_accept && (byte_data == SYNC_BYTE)) begin
                    w_state_nxt = COLLECT;
                end else begin
                    w_state_nxt = HUNT;
                end
            end
            COLLECT: begin
                if (w_accept && w_last) begin
                    if (w_pass) begin
                        w_state_nxt = EMIT;
                        w_load      = 1'b1;
                    end else begin
                        w_state_nxt = HUNT;
                        w_err       = 1'b1;
                    end
                end else if (w_timeout) begin
                    w_state_nxt = HUNT;
                    w_err       = 1'b1;
                end else begin
                    w_state_nxt = COLLECT;
                end
            end
            EMIT: begin
                if (event_ready) begin
                    w_state_nxt = HUNT;
                    w_done      = 1'b1;
                end else begin
                    w_state_nxt = EMIT;
                end
            end
            default: begin
                w_state_nxt = HUNT;
            end
        endcase
    end

    // Byte index and inter-byte idle counter; both only run inside a packet.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_idx  <= 3'd0;
            r_idle <= '0;
        end else if (r_state != COLLECT) begin
            r_idx  <= 3'd0;
            r_idle <= '0;
        end else if (w_accept) begin
            r_idx  <= r_idx + 3'd1;
            r_idle <= '0;
        end else begin
            r_idle <= r_idle + 1'b1;
        end
    end

    // Packet field capture; reserved flag bits are simply never stored.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_x_lo  <= 8'd0;
            r_y_lo  <= 8'd0;
            r_x8    <= 1'b0;
            r_y8    <= 1'b0;
            r_pol   <= 1'b0;
            r_ts_hi <= 8'd0;
`ifdef UNPACK_CHECKSUM_EN
            r_ts_lo <= 8'd0;
            r_csum  <= 8'd0;
`endif
        end else if ((r_state == COLLECT) && w_accept) begin
            case (r_idx)
                3'd0: r_x_lo <= byte_data;
                3'd1: r_y_lo <= byte_data;
                3'd2: begin
                    r_pol <= byte_data[7];
                    r_y8  <= byte_data[1];
                    r_x8  <= byte_data[0];
                end
                3'd3: r_ts_hi <= byte_data;
`ifdef UNPACK_CHECKSUM_EN
                3'd4: r_ts_lo <= byte_data;
`endif
                default: ;
            endcase
`ifdef UNPACK_CHECKSUM_EN
            r_csum <= f_xor_step(r_csum, byte_data);
        end else if (r_state == HUNT) begin
            r_csum <= 8'd0;
`endif
        end
    end

    // Event output registers, held stable for the whole EMIT state.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ev_valid <= 1'b0;
            r_ev_x     <= 9'd0;
            r_ev_y     <= 9'd0;
            r_ev_pol   <= 1'b0;
            r_ev_ts    <= 16'd0;
        end else if (w_load) begin
            r_ev_valid <= 1'b1;
            r_ev_x     <= w_x;
            r_ev_y     <= w_y;
            r_ev_pol   <= r_pol;
            r_ev_ts    <= {r_ts_hi, w_ts_lo};
        end else if (w_done) begin
            r_ev_valid <= 1'b0;
        end
    end

    // Saturating event and drop counters; one error strobe covers every drop cause.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pkt_cnt <= 8'd0;
            r_err_cnt <= 8'd0;
        end else begin
            if (w_done) begin
                r_pkt_cnt <= f_sat_inc(r_pkt_cnt);
            end
            if (w_err) begin
                r_err_cnt <= f_sat_inc(r_err_cnt);
            end
        end
    end

endmodule

// File: tb/tb_dvs_event_unpacker.sv
// Scoreboard bench for dvs_event_unpacker: stimulus pushes expected events, a negedge
// monitor pops and compares on each event handshake.
module tb_dvs_event_unpacker;

    logic        clk = 1'b0;
    logic        rst;
    logic        byte_valid;
    logic [7:0]  byte_data;
    logic        byte_ready;
    logic        event_valid;
    logic        event_ready;
    logic [8:0]  event_x;
    logic [8:0]  event_y;
    logic        event_polarity;
    logic [15:0] event_ts;
    logic [7:0]  pkt_count;
    logic [7:0]  err_count;

    int          total = 0;
    int          bad   = 0;
    int          exp_pkt = 0;
    int          exp_err = 0;
    logic [34:0] exp_q[$];
    logic [34:0] mon_e;

    dvs_event_unpacker dut (
        .clk            (clk),
        .rst            (rst),
        .byte_valid     (byte_valid),
        .byte_data      (byte_data),
        .byte_ready     (byte_ready),
        .event_valid    (event_valid),
        .event_ready    (event_ready),
        .event_x        (event_x),
        .event_y        (event_y),
        .event_polarity (event_polarity),
        .event_ts       (event_ts),
        .pkt_count      (pkt_count),
        .err_count      (err_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Monitor: every completed event handshake must match the oldest expected event.
    always @(negedge clk) begin
        if (!rst && event_valid && event_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_event", {29'd0, event_x, event_y, event_polarity, event_ts}, 64'd0);
            end else begin
                mon_e = exp_q.pop_front();
                chk("event_fields", {29'd0, event_x, event_y, event_polarity, event_ts}, {29'd0, mon_e});
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        int n;
        @(negedge clk);
        byte_valid = 1'b1;
        byte_data  = b;
        n = 0;
        while (!byte_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!byte_ready) chk("byte_ready_wait", 64'(byte_ready), 64'd1);
        @(posedge clk);
        #1;
        byte_valid = 1'b0;
    endtask

    task automatic sat_inc(inout int c);
        if (c < 255) c++;
    endtask

    task automatic send_pkt(input logic [8:0] x, input logic [8:0] y, input logic pol,
                            input logic [15:0] ts, input bit corrupt);
        logic [7:0] fl;
        bit         ok;
        fl = {pol, 5'b0, y[8], x[8]};
        ok = (x < 9'd320) && (y < 9'd320) && !corrupt;
        if (ok) exp_q.push_back({x, y, pol, ts});
        send_byte(8'hA5);
        send_byte(x[7:0]);
        send_byte(y[7:0]);
        send_byte(fl);
        send_byte(ts[15:8]);
`ifdef UNPACK_CHECKSUM_EN
        send_byte(ts[7:0]);
        send_byte(x[7:0] ^ y[7:0] ^ fl ^ ts[15:8] ^ ts[7:0] ^ {7'd0, corrupt});
`else
        send_byte(ts[7:0]);
`endif
        chk("event_valid_latency", 64'(event_valid), 64'(ok));
        chk("byte_ready_after_pkt", 64'(byte_ready), 64'(!ok));
        if (!ok) sat_inc(exp_err);
        else if (event_ready) sat_inc(exp_pkt);
    endtask

    task automatic check_counts(input string nm);
        repeat (2) @(posedge clk);
        #1;
        chk({nm, "_pkt"}, 64'(pkt_count), 64'(exp_pkt));
        chk({nm, "_err"}, 64'(err_count), 64'(exp_err));
    endtask

    initial begin
        rst         = 1'b1;
        byte_valid  = 1'b0;
        byte_data   = 8'h00;
        event_ready = 1'b1;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_byte_ready", 64'(byte_ready), 64'd0);
        chk("rst_outputs", {15'd0, event_valid, event_x, event_y, event_polarity, event_ts, pkt_count, err_count}, 64'd0);
        rst = 1'b0;
        #1;
        chk("post_rst_byte_ready", 64'(byte_ready), 64'd1);

        // Main function and range boundaries
        send_pkt(9'h13F, 9'h020, 1'b1, 16'h1234, 1'b0);
        check_counts("valid1");
        send_pkt(9'd320, 9'd0, 1'b0, 16'h0000, 1'b0);
        check_counts("x_oor");
        send_pkt(9'd5, 9'd320, 1'b1, 16'hBEEF, 1'b0);
        send_pkt(9'd0, 9'd319, 1'b0, 16'hFFFF, 1'b0);
        send_pkt(9'h0A5, 9'h0A5, 1'b1, 16'hA5A5, 1'b0);
        check_counts("boundaries");
`ifdef UNPACK_CHECKSUM_EN
        send_pkt(9'h13F, 9'h020, 1'b1, 16'h1234, 1'b1);
        check_counts("bad_csum");
`endif

        // Backpressure: event held for 10 cycles with inputs blocked
        event_ready = 1'b0;
        send_pkt(9'd100, 9'd200, 1'b0, 16'h0F0F, 1'b0);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            chk("bp_hold", {28'd0, event_valid, byte_ready, event_x, event_y, event_polarity, event_ts},
                {28'd0, 1'b1, 1'b0, 9'd100, 9'd200, 1'b0, 16'h0F0F});
        end
        event_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("bp_release_valid", 64'(event_valid), 64'd0);
        sat_inc(exp_pkt);
        check_counts("bp");

        // Garbage, partial packet, then inter-byte timeout
        send_byte(8'h00);
        send_byte(8'hFF);
        send_byte(8'hA5);
        send_byte(8'h10);
        send_byte(8'h20);
        repeat (1199) @(posedge clk);
        #1;
        chk("timeout_not_yet", 64'(err_count), 64'(exp_err));
        @(posedge clk);
        #1;
        sat_inc(exp_err);
        chk("timeout_err", 64'(err_count), 64'(exp_err));
        send_pkt(9'd1, 9'd2, 1'b1, 16'h5678, 1'b0);
        check_counts("after_timeout");

        // Reset mid-packet abandons it and clears the counters
        send_byte(8'hA5);
        send_byte(8'h3F);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("midrst_byte_ready", 64'(byte_ready), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_pkt = 0;
        exp_err = 0;
        check_counts("midrst");
        send_pkt(9'd7, 9'd8, 1'b0, 16'h0102, 1'b0);
        check_counts("post_midrst");

        // Error counter saturation
        for (int i = 0; i < 300; i++) begin
            send_pkt(9'd320, 9'd0, 1'b0, 16'h0000, 1'b0);
        end
        check_counts("sat");
        chk("sat_value", 64'(err_count), 64'd255);

        repeat (3) @(posedge clk);
        chk("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
